// File: rtl/clkmgr_pkg.sv
// Shared definitions for the clock domain manager.
//   - clk_state_t   : reset-sequencing FSM states
//   - cnt_width()   : width of a counter that must hold 0..n-1
//   - div_reset_value(): divider value every channel starts from after reset
package clkmgr_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        HOLD_RST  = 2'd2,
        RUN       = 2'd3
    } clk_state_t;

    // Width of a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Every divider (active and shadow) comes out of reset at DEFAULT_DIV.
    function automatic int div_reset_value(input int default_div);
        return default_div;
    endfunction

endpackage

// File: rtl/clock_domain_manager_ce_divider.sv
// One clock-enable channel.
//   clock, reset : system clock, synchronous active-high reset
//   run          : 1 when the manager will be in RUN during the next cycle
//   we, div      : divider write strobe and value for this channel
//   ce           : registered clock-enable strobe
// In RUN, writes land in the shadow register and become active at the next
// period wrap; outside RUN they take effect immediately. cnt_reg holds the
// position of the current cycle inside the period, so the pulse for a
// period is already on the output when a write arrives in its last cycle.
module ce_divider
    import clkmgr_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             we,
    input  logic [DIV_W-1:0] div,
    output logic             ce
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(div_reset_value(DEFAULT_DIV));
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [DIV_W-1:0] active_reg, active_next;
    logic [DIV_W-1:0] shadow_reg, shadow_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic             running_reg;
    logic             ce_reg, ce_next;
    logic             wrap;

    always_comb begin
        // d<=1 wraps every cycle; otherwise the last cycle of the period wraps.
        wrap        = (active_reg <= ONE) || (cnt_reg == active_reg - ONE);
        shadow_next = we ? div : shadow_reg;
        active_next = active_reg;
        cnt_next    = '0;

        if (!running_reg) begin
            if (we) begin
                active_next = div;
            end
        end else if (wrap) begin
            // shadow_next so a write in the wrap cycle itself is taken.
            active_next = shadow_next;
        end

        // Entering RUN starts a fresh period at position 0.
        if (run && running_reg && !wrap) begin
            cnt_next = cnt_reg + ONE;
        end

        ce_next = run && ((active_next <= ONE) || (cnt_next == active_next - ONE));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active_reg  <= RESET_DIV;
            shadow_reg  <= RESET_DIV;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            ce_reg      <= 1'b0;
        end else begin
            active_reg  <= active_next;
            shadow_reg  <= shadow_next;
            cnt_reg     <= cnt_next;
            running_reg <= run;
            ce_reg      <= ce_next;
        end
    end

    assign ce = ce_reg;

endmodule

// File: rtl/clock_domain_manager.sv
// PLL lock sequencer and clock-enable generator.
//   clock, reset     : PLL output clock, synchronous active-high reset
//   pll_locked       : raw lock flag (asynchronous, synchronised here)
//   cfg_we/ch/div    : divider write port, out-of-range channels ignored
//   lost_clear       : clears lock_lost and lock_loss_count
//   sys_reset, ready : downstream reset (released only in RUN) and RUN flag
//   ce               : per-channel clock-enable strobes (0 outside RUN)
//   lock_lost        : sticky, set when lock drops during RUN
//   lock_loss_count  : saturating count of lock drops during RUN
module clock_domain_manager
    import clkmgr_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int DIV_W              = 16,
    parameter int DEFAULT_DIV        = 17,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int CNT_W              = 8,
    localparam int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              lost_clear,
    output logic              sys_reset,
    output logic              ready,
    output logic [NUM_CH-1:0] ce,
    output logic              lock_lost,
    output logic [CNT_W-1:0]  lock_loss_count
);

    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int HOLD_W   = cnt_width(RST_HOLD_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic                sync1_reg, lock_s;
    clk_state_t          state_reg, state_next;
    logic [STABLE_W-1:0] stable_cnt_reg, stable_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                sys_reset_reg, sys_reset_next;
    logic                ready_reg, ready_next;
    logic                lock_lost_reg;
    logic [CNT_W-1:0]    loss_cnt_reg;
    logic                run_next, loss_event;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync1_reg <= pll_locked;
            lock_s    <= sync1_reg;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= WAIT_LOCK;
            stable_cnt_reg <= '0;
            hold_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            stable_cnt_reg <= stable_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    // Next-state logic: any loss of lock falls straight back to WAIT_LOCK.
    always_comb begin
        state_next      = state_reg;
        stable_cnt_next = stable_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        case (state_reg)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next      = STABILISE;
                    stable_cnt_next = '0;
                end
            end
            STABILISE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (stable_cnt_reg == STABLE_LAST) begin
                    state_next    = HOLD_RST;
                    hold_cnt_next = '0;
                end else begin
                    stable_cnt_next = stable_cnt_reg + STABLE_W'(1);
                end
            end
            HOLD_RST: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Output logic: derived from the next state so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        run_next       = (state_next == RUN);
        sys_reset_next = !run_next;
        ready_next     = run_next;
        loss_event     = (state_reg == RUN) && !lock_s;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sys_reset_reg <= 1'b1;
            ready_reg     <= 1'b0;
            lock_lost_reg <= 1'b0;
            loss_cnt_reg  <= '0;
        end else begin
            sys_reset_reg <= sys_reset_next;
            ready_reg     <= ready_next;
            if (loss_event) begin
                lock_lost_reg <= 1'b1;
                // A clear coinciding with a loss leaves exactly that one loss.
                if (lost_clear) begin
                    loss_cnt_reg <= CNT_W'(1);
                end else if (loss_cnt_reg != {CNT_W{1'b1}}) begin
                    loss_cnt_reg <= loss_cnt_reg + CNT_W'(1);
                end
            end else if (lost_clear) begin
                lock_lost_reg <= 1'b0;
                loss_cnt_reg  <= '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic ch_we;
            assign ch_we = cfg_we && (int'(cfg_ch) == gi);

            ce_divider #(
                .DIV_W      (DIV_W),
                .DEFAULT_DIV(DEFAULT_DIV)
            ) u_div (
                .clock(clock),
                .reset(reset),
                .run  (run_next),
                .we   (ch_we),
                .div  (cfg_div),
                .ce   (ce[gi])
            );
        end
    endgenerate

    assign sys_reset       = sys_reset_reg;
    assign ready           = ready_reg;
    assign lock_lost       = lock_lost_reg;
    assign lock_loss_count = loss_cnt_reg;

endmodule

// File: tb/tb_clock_domain_manager.sv
// Scoreboard bench for clock_domain_manager (S=8, H=4, NUM_CH=2, CNT_W=2).
// The stimulus process pushes the expected post-edge outputs from a
// behavioural model; a monitor pops one entry after every rising edge.
module tb_clock_domain_manager;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 17;
    localparam int S           = 8;
    localparam int H           = 4;
    localparam int CNT_W       = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              pll_locked = 1'b0;
    logic              cfg_we = 1'b0;
    logic [0:0]        cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              lost_clear = 1'b0;
    logic              sys_reset, ready, lock_lost;
    logic [NUM_CH-1:0] ce;
    logic [CNT_W-1:0]  lock_loss_count;

    clock_domain_manager #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV),
        .LOCK_STABLE_CYCLES(S), .RST_HOLD_CYCLES(H), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .pll_locked(pll_locked),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .lost_clear(lost_clear), .sys_reset(sys_reset), .ready(ready),
        .ce(ce), .lock_lost(lock_lost), .lock_loss_count(lock_loss_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              sys_reset;
        logic              ready;
        logic [NUM_CH-1:0] ce;
        logic              lock_lost;
        logic [CNT_W-1:0]  count;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_no = 0;

    // Reference model: lock history, consecutive-lock length, per-channel
    // period position, active divider and pending write.
    bit m_h1, m_h2;
    int m_len, m_cnt;
    bit m_lost;
    int m_act[NUM_CH];
    int m_pend[NUM_CH];
    bit m_pend_v[NUM_CH];
    int m_pos[NUM_CH];

    // Predict outputs after the coming edge from the inputs now applied.
    // The manager is in RUN exactly when the synced lock has been seen high
    // on more than S+H consecutive edges.
    task automatic model_edge();
        obs_t e;
        bit   seen, was_run, now_run, we_i;
        e = '0;
        if (reset) begin
            m_h1 = 0; m_h2 = 0; m_len = 0; m_lost = 0; m_cnt = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_act[i] = DEFAULT_DIV; m_pend_v[i] = 0; m_pos[i] = 0;
            end
            e.sys_reset = 1'b1;
        end else begin
            seen = m_h2; m_h2 = m_h1; m_h1 = pll_locked;
            was_run = (m_len > S + H);
            if (seen) begin
                if (m_len <= S + H) m_len++;
            end else begin
                m_len = 0;
            end
            now_run = (m_len > S + H);
            if (was_run && !seen) begin
                m_lost = 1;
                m_cnt  = lost_clear ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            end else if (lost_clear) begin
                m_lost = 0; m_cnt = 0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                we_i = cfg_we && (int'(cfg_ch) == i);
                if (!was_run) begin
                    if (we_i) begin m_act[i] = int'(cfg_div); m_pend_v[i] = 0; end
                end else begin
                    if (we_i) begin m_pend[i] = int'(cfg_div); m_pend_v[i] = 1; end
                    if (m_act[i] <= 1 || m_pos[i] == m_act[i] - 1) begin
                        if (m_pend_v[i]) begin m_act[i] = m_pend[i]; m_pend_v[i] = 0; end
                        m_pos[i] = 0;
                    end else begin
                        m_pos[i]++;
                    end
                end
                if (!now_run || !was_run) m_pos[i] = 0;
                e.ce[i] = now_run && (m_act[i] <= 1 || m_pos[i] == m_act[i] - 1);
            end
            e.sys_reset = !now_run;
            e.ready     = now_run;
            e.lock_lost = m_lost;
            e.count     = CNT_W'(m_cnt);
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(negedge clock);
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (sys_reset !== 1'b0 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic count_ce(input int ch, input int cycles, output int hits);
        hits = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (ce[ch] === 1'b1) hits++;
        end
    endtask

    task automatic write_div(input int ch, input int val);
        cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_div = DIV_W'(val);
        step();
        cfg_we = 1'b0;
    endtask

    // Monitor: one scoreboard comparison per rising edge.
    obs_t mon_e, mon_a;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            edge_no++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {sys_reset, ready, ce, lock_lost, lock_loss_count};
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL outputs edge=%0d got sr=%b rdy=%b ce=%b lost=%b cnt=%0d want sr=%b rdy=%b ce=%b lost=%b cnt=%0d",
                             edge_no, mon_a.sys_reset, mon_a.ready, mon_a.ce, mon_a.lock_lost, mon_a.count,
                             mon_e.sys_reset, mon_e.ready, mon_e.ce, mon_e.lock_lost, mon_e.count);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hits, dlen;

        // Reset, then lock rises just before edge 1 of the sequence.
        reset = 1'b1;
        repeat (3) step();
        check_eq("reset_sys_reset", int'(sys_reset), 1);
        check_eq("reset_ce", int'(ce), 0);
        reset = 1'b0; pll_locked = 1'b1;
        wait_release(n);
        check_eq("release_latency", n, 3 + S + H);
        check_eq("ready_at_release", int'(ready), 1);

        // Divider behaviour in RUN.
        count_ce(0, 34, hits);
        check_eq("ch0_div17_pulses", hits, 2);
        write_div(1, 1);
        repeat (20) step();
        count_ce(1, 20, hits);
        check_eq("ch1_div1_constant", hits, 20);
        write_div(1, 0);
        repeat (5) step();
        count_ce(1, 20, hits);
        check_eq("ch1_div0_constant", hits, 20);
        repeat (3) step();
        write_div(0, 5);
        repeat (20) step();
        count_ce(0, 40, hits);
        check_eq("ch0_div5_pulses", hits, 8);
        for (int k = 0; k < 6; k++) begin
            write_div(0, 17);
            write_div(0, 5);
            repeat (k * 3) step();
        end
        write_div(0, 17);
        repeat (20) step();

        // Repeated lock drops in RUN: count saturates at CNT_MAX.
        for (int k = 1; k <= 4; k++) begin
            dlen = 1 + int'($urandom_range(0, 2));
            pll_locked = 1'b0;
            repeat (dlen) step();
            pll_locked = 1'b1;
            repeat (3) step();
            check_eq("lost_after_drop", int'(lock_lost), 1);
            wait_release(n);
            check_eq("relock_released", int'(sys_reset), 0);
            check_eq("loss_count", int'(lock_loss_count), (k < CNT_MAX) ? k : CNT_MAX);
        end

        // lost_clear coinciding with the loss event.
        lost_clear = 1'b1; pll_locked = 1'b0;
        repeat (3) step();
        lost_clear = 1'b0;
        check_eq("clear_with_loss_lost", int'(lock_lost), 1);
        check_eq("clear_with_loss_count", int'(lock_loss_count), 1);

        // One-cycle glitch while stabilising restarts the whole sequence.
        pll_locked = 1'b1;
        repeat (5) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_release(n);
        check_eq("glitch_release_latency", n, 3 + S + H);
        check_eq("glitch_count_unchanged", int'(lock_loss_count), 1);

        // reset in RUN with a sticky loss and a modified divider.
        write_div(0, 5);
        repeat (20) step();
        reset = 1'b1;
        step();
        check_eq("midreset_sys_reset", int'(sys_reset), 1);
        check_eq("midreset_ce", int'(ce), 0);
        check_eq("midreset_lost", int'(lock_lost), 0);
        check_eq("midreset_count", int'(lock_loss_count), 0);
        reset = 1'b0;
        wait_release(n);
        check_eq("midreset_release", n, 3 + S + H);
        count_ce(0, 34, hits);
        check_eq("midreset_div_default", hits, 2);

        // Randomised traffic, checked entirely by the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_ch     = 1'($urandom_range(0, 1));
            cfg_div    = DIV_W'($urandom_range(0, 23));
            lost_clear = ($urandom_range(0, 49) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            if (pll_locked && $urandom_range(0, 199) == 0) pll_locked = 1'b0;
            else if (!pll_locked && $urandom_range(0, 2) == 0) pll_locked = 1'b1;
            step();
        end

        cfg_we = 1'b0; lost_clear = 1'b0; reset = 1'b0;
        repeat (2) step();
        check_eq("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
